inout_bus_peer: RTL and testbench

//  Far-end partner on a shared half-duplex tristate byte bus. Owns bus direction via peer_out_en
//  (wired to the partner's out_en). Drives queued TX words while the partner is tristated, samples
//  the partner's word while it drives. Guarantees contention-free turnaround in both directions.

---
 rtl/inout_bus_pkg.sv | 6 +
 rtl/inout_bus_txfifo.sv | 38 +++
 rtl/inout_bus_peer.sv | 111 +++++++++++
 tb/tb_inout_bus_peer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/inout_bus_pkg.sv
// inout_bus_pkg: shared state encoding and default widths for the tristate bus peer
package inout_bus_pkg;
  typedef enum logic [1:0] {RX, TURN_TX, TX, TURN_RX} state_t;
  localparam int DEF_DW = 8;
  localparam int DEF_TURN = 2;
endpackage

// File: rtl/inout_bus_txfifo.sv
// inout_bus_txfifo: synchronous TX FIFO with head exposed for direct bus drive
module inout_bus_txfifo import inout_bus_pkg::*; #(
  parameter int DW = DEF_DW,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DW-1:0]          din,
  output logic                   full,
  output logic                   empty,
  output logic [DW-1:0]          head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/inout_bus_peer.sv
// inout_bus_peer: half-duplex tristate bus partner with guarded turnaround in both directions
module inout_bus_peer import inout_bus_pkg::*; #(
  parameter int DW = DEF_DW,
  parameter int FIFO_DEPTH = 4,
  parameter int TURN = DEF_TURN,
  parameter int SAMPLE_PER = 8,
  parameter int BURST_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  inout  wire  [DW-1:0] bus,
  output logic          peer_out_en,
  input  logic [DW-1:0] tx_data,
  input  logic          tx_valid,
  output logic          tx_ready,
  output logic [DW-1:0] rx_data,
  output logic          rx_valid,
  input  logic          rx_ready,
  output logic          rx_overflow
);
  localparam int SW = $clog2(SAMPLE_PER);
  localparam int TW = $clog2(TURN + 1);
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t state;
  logic [SW-1:0] samp_cnt;
  logic [TW-1:0] turn_cnt;
  logic [BW-1:0] burst_cnt;
  logic [CW-1:0] count;
  logic [DW-1:0] head;
  logic drive_en, full, empty, wrap, turn_done, last_pop;
  logic [7:0] pe_age, off_age;
  assign tx_ready = !full;
  assign wrap = samp_cnt == SW'(SAMPLE_PER - 1);
  assign turn_done = turn_cnt == TW'(TURN - 1);
  assign last_pop = burst_cnt == BW'(BURST_MAX - 1) || count == CW'(1);
  assign bus = drive_en ? head : {DW{1'bz}};
  inout_bus_txfifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(tx_valid && tx_ready), .pop(state == TX),
    .din(tx_data), .full(full), .empty(empty), .head(head), .count(count)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= RX;
      samp_cnt <= '0;
      turn_cnt <= '0;
      burst_cnt <= '0;
      peer_out_en <= 1'b0;
      drive_en <= 1'b0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      rx_overflow <= 1'b0;
    end else begin
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      case (state)
        RX: begin
          samp_cnt <= wrap ? '0 : samp_cnt + 1'b1;
          if (wrap) begin
            // an unconsumed word is kept; the newer capture is flagged instead
            if (!rx_valid || rx_ready) begin
              rx_data <= bus;
              rx_valid <= 1'b1;
            end else rx_overflow <= 1'b1;
            if (!empty) begin
              state <= TURN_TX;
              peer_out_en <= 1'b1;
              turn_cnt <= '0;
            end
          end
        end
        TURN_TX: begin
          turn_cnt <= turn_cnt + 1'b1;
          if (turn_done) begin
            state <= TX;
            drive_en <= 1'b1;
            burst_cnt <= '0;
          end
        end
        TX: begin
          burst_cnt <= burst_cnt + 1'b1;
          if (last_pop) begin
            state <= TURN_RX;
            drive_en <= 1'b0;
            turn_cnt <= '0;
          end
        end
        TURN_RX: begin
          turn_cnt <= turn_cnt + 1'b1;
          if (turn_done) begin
            state <= RX;
            peer_out_en <= 1'b0;
            samp_cnt <= '0;
          end
        end
        default: state <= RX;
      endcase
    end
  // consecutive prior cycles with partner released / with us released, saturating
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pe_age <= '0;
      off_age <= '0;
    end else begin
      pe_age <= !peer_out_en ? '0 : pe_age == 8'hff ? pe_age : pe_age + 1'b1;
      off_age <= drive_en ? '0 : off_age == 8'hff ? off_age : off_age + 1'b1;
    end
  a_drive_after_turn: assert property (@(posedge clk) disable iff (reset)
    drive_en |-> pe_age >= 8'(TURN));
  a_release_after_turn: assert property (@(posedge clk) disable iff (reset)
    (!peer_out_en && pe_age != 8'h00) |-> off_age >= 8'(TURN));
endmodule

// File: tb/tb_inout_bus_peer.sv
// tb_inout_bus_peer: directed and randomized checks of turnaround, TX bursts and RX handshake
module tb_inout_bus_peer;
  import inout_bus_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  wire [7:0] bus;
  logic peer_out_en, tx_ready, rx_valid, rx_overflow;
  logic tx_valid = 1'b0;
  logic rx_ready = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] partner_val = 8'h5A;
  logic [7:0] rx_data;
  int total = 0;
  int bad = 0;
  logic [7:0] q[$];
  assign bus = peer_out_en ? 8'hzz : partner_val;
  always #5 clk = ~clk;
  inout_bus_peer dut (
    .clk(clk), .reset(reset), .bus(bus), .peer_out_en(peer_out_en),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_overflow(rx_overflow)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  task automatic push(input logic [7:0] d, input logic exp_rdy);
    tx_data = d;
    tx_valid = 1'b1;
    chk("push_ready", {31'b0, tx_ready}, {31'b0, exp_rdy});
    step();
    tx_valid = 1'b0;
  endtask
  task automatic wait_peer(input int lim);
    int n = 0;
    while (peer_out_en !== 1'b1 && n < lim) begin
      step();
      n++;
    end
    chk("peer_rise", {31'b0, peer_out_en}, 32'd1);
  endtask
  // called at the first cycle the partner is released; optionally pushes pd during word pidx
  task automatic expect_window(input int n, input logic [31:0] words, input int pidx, input logic [7:0] pd);
    for (int t = 0; t < 2; t++) begin
      chk("turn_tx_peer", {31'b0, peer_out_en}, 32'd1);
      chk("turn_tx_drive", {31'b0, dut.drive_en}, 32'd0);
      step();
    end
    for (int i = 0; i < n; i++) begin
      chk("tx_drive", {31'b0, dut.drive_en}, 32'd1);
      chk("tx_word", {24'b0, bus}, {24'b0, words[8*i +: 8]});
      if (i == pidx) begin
        tx_data = pd;
        tx_valid = 1'b1;
        chk("tx_ready_after_pop", {31'b0, tx_ready}, 32'd1);
      end
      step();
      tx_valid = 1'b0;
    end
    for (int t = 0; t < 2; t++) begin
      chk("turn_rx_drive", {31'b0, dut.drive_en}, 32'd0);
      chk("turn_rx_peer", {31'b0, peer_out_en}, 32'd1);
      step();
    end
    chk("back_to_rx", {31'b0, peer_out_en}, 32'd0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    step();
    step();
    chk("rst_peer", {31'b0, peer_out_en}, 32'd0);
    chk("rst_drive", {31'b0, dut.drive_en}, 32'd0);
    chk("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
    chk("rst_rx_data", {24'b0, rx_data}, 32'h0);
    chk("rst_overflow", {31'b0, rx_overflow}, 32'd0);
    chk("rst_tx_ready", {31'b0, tx_ready}, 32'd1);
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("t1_peer_low", {31'b0, peer_out_en}, 32'd0);
      if (k == 7) chk("t1_no_capture_yet", {31'b0, rx_valid}, 32'd0);
    end
    chk("t1_rx_valid", {31'b0, rx_valid}, 32'd1);
    chk("t1_rx_data", {24'b0, rx_data}, 32'h5A);
    rx_ready = 1'b1;
    step();
    chk("t1_consumed", {31'b0, rx_valid}, 32'd0);
    push(8'h11, 1'b1);
    push(8'h22, 1'b1);
    wait_peer(20);
    expect_window(2, 32'h0000_2211, -1, 8'h00);
    for (int i = 0; i < 6; i++) begin
      tx_data = 8'h31 + 8'(i);
      tx_valid = 1'b1;
      chk("t3_tx_ready", {31'b0, tx_ready}, {31'b0, i < 4});
      step();
    end
    tx_valid = 1'b0;
    wait_peer(20);
    expect_window(4, 32'h3433_3231, 1, 8'h3E);
    wait_peer(20);
    expect_window(1, 32'h0000_003E, -1, 8'h00);
    repeat (12) step();
    chk("t3_no_leftover_peer", {31'b0, peer_out_en}, 32'd0);
    chk("t3_empty_ready", {31'b0, tx_ready}, 32'd1);
    partner_val = 8'hA1;
    n = 0;
    while (rx_valid !== 1'b0 && n < 4) begin
      step();
      n++;
    end
    chk("t4_drained", {31'b0, rx_valid}, 32'd0);
    rx_ready = 1'b0;
    n = 0;
    while (rx_valid !== 1'b1 && n < 12) begin
      step();
      n++;
    end
    chk("t4_first_valid", {31'b0, rx_valid}, 32'd1);
    chk("t4_first_data", {24'b0, rx_data}, 32'hA1);
    chk("t4_no_overflow", {31'b0, rx_overflow}, 32'd0);
    partner_val = 8'hB2;
    repeat (8) step();
    chk("t4_held_valid", {31'b0, rx_valid}, 32'd1);
    chk("t4_not_overwritten", {24'b0, rx_data}, 32'hA1);
    chk("t4_overflow", {31'b0, rx_overflow}, 32'd1);
    rx_ready = 1'b1;
    step();
    chk("t4_popped", {31'b0, rx_valid}, 32'd0);
    chk("t4_overflow_sticky", {31'b0, rx_overflow}, 32'd1);
    rx_ready = 1'b0;
    n = 0;
    while (rx_valid !== 1'b1 && n < 12) begin
      step();
      n++;
    end
    chk("t5_sync_capture", {31'b0, rx_valid}, 32'd1);
    push(8'hF1, 1'b1);
    push(8'hF2, 1'b1);
    push(8'hF3, 1'b1);
    wait_peer(20);
    step();
    step();
    chk("t5_word1", {24'b0, bus}, 32'hF1);
    step();
    chk("t5_word2", {24'b0, bus}, 32'hF2);
    chk("t5_driving", {31'b0, dut.drive_en}, 32'd1);
    reset = 1'b1;
    #1;
    chk("t5_rst_drive", {31'b0, dut.drive_en}, 32'd0);
    chk("t5_rst_peer", {31'b0, peer_out_en}, 32'd0);
    chk("t5_rst_ready", {31'b0, tx_ready}, 32'd1);
    chk("t5_rst_state", {30'b0, dut.state}, {30'b0, RX});
    chk("t5_rst_overflow", {31'b0, rx_overflow}, 32'd0);
    step();
    reset = 1'b0;
    repeat (12) step();
    chk("t5_fifo_empty_stays_rx", {31'b0, peer_out_en}, 32'd0);
    for (int c = 0; c < 3000; c++) begin
      if (dut.drive_en === 1'b1) begin
        chk("rand_word", {24'b0, bus}, q.size() != 0 ? {24'b0, q[0]} : 32'hxxxx_xxxx);
        if (q.size() != 0) void'(q.pop_front());
      end
      tx_valid = 1'($urandom_range(0, 1));
      tx_data = 8'($urandom);
      rx_ready = 1'($urandom_range(0, 1));
      partner_val = 8'($urandom);
      if (tx_valid && tx_ready) q.push_back(tx_data);
      step();
    end
    tx_valid = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      if (dut.drive_en === 1'b1) begin
        chk("drain_word", {24'b0, bus}, {24'b0, q[0]});
        void'(q.pop_front());
      end
      step();
      n++;
    end
    chk("drain_all_sent", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
